// File: rtl/universal_register.sv
// General-purpose WIDTH-bit datapath register: load, shift/rotate, inc/dec,
// plus a handshaked multi-cycle burst shift/rotate (IDLE -> BURST -> DONE).
module universal_register #(
   parameter int WIDTH = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             E,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CW-1:0]    cnt,
   output logic [WIDTH-1:0] Q,
   output logic             carry,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    remaining, remaining_next;
   logic [2:0]       burst_mode, burst_mode_next;
   logic [WIDTH-1:0] q_next;
   logic             carry_next;
   logic [2:0]       exec_mode;
   logic [WIDTH:0]   op_result;

   function automatic logic is_shift(input logic [2:0] m);
      return m inside {[3'b010:3'b101]};
   endfunction

   // Result is {carry, Q} after one execution of mode m.
   function automatic logic [WIDTH:0] apply_op(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] q,
      input logic             c,
      input logic [WIDTH-1:0] d,
      input logic             sl,
      input logic             sr
   );
      case (m)
         3'b001:  return {1'b0, d};
         3'b010:  return {q[WIDTH-1], q[WIDTH-2:0], sr};
         3'b011:  return {q[0], sl, q[WIDTH-1:1]};
         3'b100:  return {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
         3'b101:  return {q[0], q[0], q[WIDTH-1:1]};
         3'b110:  return {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
         3'b111:  return {(q == '0), q - WIDTH'(1)};
         default: return {c, q};
      endcase
   endfunction

   assign exec_mode = (state == BURST) ? burst_mode : mode;
   assign op_result = apply_op(exec_mode, Q, carry, D, sin_l, sin_r);

   always_comb begin
      state_next      = state;
      q_next          = Q;
      carry_next      = carry;
      remaining_next  = remaining;
      burst_mode_next = burst_mode;
      case (state)
         IDLE: begin
            if (E) begin
               if (start && is_shift(mode)) begin
                  burst_mode_next = mode;
                  if (cnt == '0) begin
                     state_next = DONE;
                  end else begin
                     {carry_next, q_next} = op_result;
                     remaining_next       = cnt - CW'(1);
                     state_next           = (cnt == CW'(1)) ? DONE : BURST;
                  end
               end else begin
                  {carry_next, q_next} = op_result;
               end
            end
         end
         BURST: begin
            // Pausing with E low freezes Q, carry and the remaining count.
            if (E) begin
               {carry_next, q_next} = op_result;
               remaining_next       = remaining - CW'(1);
               if (remaining == CW'(1)) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         Q          <= RESET_VALUE;
         carry      <= 1'b0;
         remaining  <= '0;
         burst_mode <= '0;
      end else begin
         state      <= state_next;
         Q          <= q_next;
         carry      <= carry_next;
         remaining  <= remaining_next;
         burst_mode <= burst_mode_next;
      end
   end

   assign busy = (state == BURST);
   assign done = (state == DONE);
   assign zero = (Q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register (WIDTH=4, RESET_VALUE=4'hA): vector table,
// hand-written burst sequences, then random stimulus against an arithmetic model.
module tb_universal_register;

   localparam int W    = 4;
   localparam int CW   = 3;
   localparam int FULL = 16;
   localparam int HALF = 8;
   localparam logic [W-1:0] RV = 4'hA;

   logic          clk = 1'b0;
   logic          rst, e, sin_l, sin_r, start;
   logic [2:0]    mode;
   logic [W-1:0]  d;
   logic [CW-1:0] cnt;
   logic [W-1:0]  q;
   logic          carry, zero, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: integers, burst tracked as a count of pending shifts.
   int m_q, m_c, m_rem, m_op;
   bit m_done;

   typedef struct {
      logic rst, e;
      logic [2:0] mode;
      logic [3:0] d;
      logic sl, sr, st;
      logic [2:0] cnt;
      logic [3:0] xq;
      logic xc, xb, xd;
   } vec_t;

   vec_t tbl[17];

   universal_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clk(clk), .rst(rst), .E(e), .mode(mode), .D(d), .sin_l(sin_l),
      .sin_r(sin_r), .start(start), .cnt(cnt), .Q(q), .carry(carry),
      .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int r, int en, int md, int dd, int sl, int sr,
                               int st, int cn, int xq, int xc, int xb, int xd);
      vec_t v;
      v.rst = r[0]; v.e = en[0]; v.mode = md[2:0]; v.d = dd[3:0];
      v.sl = sl[0]; v.sr = sr[0]; v.st = st[0]; v.cnt = cn[2:0];
      v.xq = xq[3:0]; v.xc = xc[0]; v.xb = xb[0]; v.xd = xd[0];
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_apply(int op);
      case (op)
         1: begin m_q = int'(d); m_c = 0; end
         2: begin m_c = m_q / HALF; m_q = (m_q * 2) % FULL + int'(sin_r); end
         3: begin m_c = m_q % 2; m_q = m_q / 2 + int'(sin_l) * HALF; end
         4: begin m_c = m_q / HALF; m_q = (m_q * 2) % FULL + m_c; end
         5: begin m_c = m_q % 2; m_q = m_q / 2 + m_c * HALF; end
         6: begin m_c = (m_q == FULL - 1) ? 1 : 0; m_q = (m_q + 1) % FULL; end
         7: begin m_c = (m_q == 0) ? 1 : 0; m_q = (m_q + FULL - 1) % FULL; end
         default: ;
      endcase
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   function automatic void model_step();
      if (!rst) begin
         m_q = int'(RV); m_c = 0; m_rem = 0; m_done = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_rem > 0) begin
         if (e) begin
            model_apply(m_op);
            m_rem--;
            if (m_rem == 0) m_done = 1;
         end
      end else if (e) begin
         if (start && mode >= 3'd2 && mode <= 3'd5) begin
            m_op = int'(mode);
            if (cnt == 0) m_done = 1;
            else begin
               model_apply(m_op);
               m_rem = int'(cnt) - 1;
               if (m_rem == 0) m_done = 1;
            end
         end else begin
            model_apply(int'(mode));
         end
      end
   endfunction

   task automatic step_vec(vec_t v, string tag);
      rst = v.rst; e = v.e; mode = v.mode; d = v.d;
      sin_l = v.sl; sin_r = v.sr; start = v.st; cnt = v.cnt;
      model_step();
      @(posedge clk);
      #1;
      check({tag, " Q"}, int'(q), int'(v.xq));
      check({tag, " carry"}, int'(carry), int'(v.xc));
      check({tag, " busy"}, int'(busy), int'(v.xb));
      check({tag, " done"}, int'(done), int'(v.xd));
      check({tag, " zero"}, int'(zero), (v.xq == 4'd0) ? 1 : 0);
   endtask

   initial begin
      rst = 1'b0; e = 1'b0; mode = 3'd0; d = '0;
      sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; cnt = '0;
      m_q = 0; m_c = 0; m_rem = 0; m_op = 0; m_done = 0;

      //            rst E  md d    sl sr st cn  Q    c  b  dn
      tbl[0]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 4'hA, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0,   0, 0, 0, 0, 4'hA, 0, 0, 0);
      tbl[2]  = mk(1, 0, 1, 4'h5, 0, 0, 0, 0, 4'hA, 0, 0, 0);
      tbl[3]  = mk(1, 1, 1, 4'h5, 0, 0, 0, 0, 4'h5, 0, 0, 0);
      tbl[4]  = mk(1, 1, 1, 4'h9, 0, 0, 0, 0, 4'h9, 0, 0, 0);
      tbl[5]  = mk(1, 1, 2, 0,   0, 1, 0, 0, 4'h3, 1, 0, 0);
      tbl[6]  = mk(1, 1, 5, 0,   0, 0, 0, 0, 4'h9, 1, 0, 0);
      tbl[7]  = mk(1, 1, 3, 0,   0, 0, 0, 0, 4'h4, 1, 0, 0);
      tbl[8]  = mk(1, 1, 1, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0, 0);
      tbl[9]  = mk(1, 1, 6, 0,   0, 0, 0, 0, 4'h0, 1, 0, 0);
      tbl[10] = mk(1, 1, 7, 0,   0, 0, 0, 0, 4'hF, 1, 0, 0);
      tbl[11] = mk(1, 1, 7, 0,   0, 0, 0, 0, 4'hE, 0, 0, 0);
      tbl[12] = mk(1, 1, 1, 4'h1, 0, 0, 0, 0, 4'h1, 0, 0, 0);
      tbl[13] = mk(1, 1, 4, 0,   0, 0, 1, 3, 4'h2, 0, 1, 0);
      tbl[14] = mk(1, 1, 1, 0,   0, 0, 0, 0, 4'h4, 0, 1, 0);
      tbl[15] = mk(1, 1, 1, 0,   0, 0, 0, 0, 4'h8, 0, 0, 1);
      tbl[16] = mk(1, 1, 0, 0,   0, 0, 0, 0, 4'h8, 0, 0, 0);

      #1;
      for (int i = 0; i < 17; i++) step_vec(tbl[i], $sformatf("row%0d", i));

      // Burst ROR cnt=4 from 1000 with a 3-cycle E pause after the first shift.
      step_vec(mk(1, 1, 5, 0, 0, 0, 1, 4, 4'h4, 0, 1, 0), "pause start");
      for (int i = 0; i < 3; i++)
         step_vec(mk(1, 0, 1, 4'hF, 0, 0, 1, 2, 4'h4, 0, 1, 0), $sformatf("pause hold%0d", i));
      step_vec(mk(1, 1, 1, 4'hF, 0, 0, 0, 0, 4'h2, 0, 1, 0), "pause resume1");
      step_vec(mk(1, 1, 1, 4'hF, 0, 0, 0, 0, 4'h1, 0, 1, 0), "pause resume2");
      step_vec(mk(1, 1, 1, 4'hF, 0, 0, 1, 2, 4'h8, 1, 0, 1), "pause last");
      step_vec(mk(1, 1, 0, 0, 0, 0, 0, 0, 4'h8, 1, 0, 0), "pause idle");

      // cnt=0 burst: done next cycle, Q and carry untouched.
      step_vec(mk(1, 1, 4, 0, 0, 0, 1, 0, 4'h8, 1, 0, 1), "cnt0 start");
      step_vec(mk(1, 1, 0, 0, 0, 0, 0, 0, 4'h8, 1, 0, 0), "cnt0 after");

      // Reset mid-burst: SHL cnt=4, reset after two shifts, done must never pulse.
      step_vec(mk(1, 1, 2, 0, 0, 1, 1, 4, 4'h1, 1, 1, 0), "rstmid shift1");
      step_vec(mk(1, 1, 0, 0, 0, 1, 0, 0, 4'h3, 0, 1, 0), "rstmid shift2");
      step_vec(mk(0, 1, 0, 0, 0, 1, 0, 0, 4'hA, 0, 0, 0), "rstmid reset");
      for (int i = 0; i < 4; i++)
         step_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'hA, 0, 0, 0), $sformatf("rstmid quiet%0d", i));

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 49) != 0);
         e     = ($urandom_range(0, 4) != 0);
         mode  = 3'($urandom_range(0, 7));
         d     = 4'($urandom);
         sin_l = 1'($urandom);
         sin_r = 1'($urandom);
         start = ($urandom_range(0, 3) == 0);
         cnt   = 3'($urandom_range(0, 7));
         model_step();
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d Q", i), int'(q), m_q);
         check($sformatf("rnd%0d carry", i), int'(carry), m_c);
         check($sformatf("rnd%0d busy", i), int'(busy), (m_rem > 0) ? 1 : 0);
         check($sformatf("rnd%0d done", i), int'(done), int'(m_done));
         check($sformatf("rnd%0d zero", i), int'(zero), (m_q == 0) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the team's fixed 4-bit enable register.
- Holds a WIDTH-bit word with the following operations:
  - parallel load
  - 1-bit shift and rotate, with serial inputs
  - increment and decrement, with carry/borrow
  - a multi-cycle burst shift/rotate, handshaked by start/busy/done.
- Used as the general datapath register in lab designs: accumulators, shifters and serial converters.

Parameters:
WIDTH, 4, data width in bits (>= 2)
RESET_VALUE, 0, value loaded into Q on reset
CW, $clog2(WIDTH+1), width of the burst count input (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset
E  input  1  enable; when 0 nothing changes except by reset; an in-progress burst pauses
mode  input  3  operation select (see Behaviour)
D  input  WIDTH  parallel load data
sin_l  input  1  serial input entering the MSB on shift right
sin_r  input  1  serial input entering the LSB on shift left
start  input  1  request a burst of cnt repetitions of a shift/rotate mode
cnt  input  CW  burst length in cycles
Q  output  WIDTH  register contents
carry  output  1  bit shifted/rotated out, or inc carry / dec borrow, of the last executed op
zero  output  1  combinational (Q == 0)
busy  output  1  high while a burst is executing
done  output  1  one-cycle pulse on burst completion

Behaviour:
- Reset: rst==0 at a clock edge sets Q=RESET_VALUE, carry=0, busy=0, done=0 and the FSM to IDLE. Reset takes priority over everything, including mid-burst and E==0.
- Modes, each executed in one clock when E==1 in IDLE:
  - 000 HOLD: Q unchanged; carry unchanged.
  - 001 LOAD: Q<=D; carry<=0.
  - 010 SHL: Q<={Q[W-2:0],sin_r}; carry<=Q[W-1].
  - 011 SHR: Q<={sin_l,Q[W-1:1]}; carry<=Q[0].
  - 100 ROL: Q<={Q[W-2:0],Q[W-1]}; carry<=Q[W-1].
  - 101 ROR: Q<={Q[0],Q[W-1:1]}; carry<=Q[0].
  - 110 INC: {carry,Q}<=Q+1. Wraps from all-ones to 0 with carry=1.
  - 111 DEC: Q<=Q-1; carry<=(Q==0). Wraps from 0 to all-ones with carry=1.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If E==1 and start==1 and mode is 010..101:
    - Latch mode and cnt into internal registers.
    - If cnt==0: go to DONE; Q unchanged.
    - Otherwise: perform the first shift this edge, set remaining=cnt-1, then go to DONE if remaining==0, else BURST.
  - If start==1 with any other mode: the op executes as a normal single op; start is ignored (no busy, no done).
- BURST:
  - busy=1.
  - Each edge with E==1: perform the latched op (sin_l/sin_r are sampled live each cycle) and decrement remaining. When remaining reaches 0, go to DONE.
  - E==0: Q, carry and remaining are held.
  - mode, D, start and cnt inputs are ignored.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state is IDLE unconditionally, regardless of E.
  - start in DONE is ignored, so back-to-back bursts are spaced by at least one cycle.
- busy timing: busy is registered. It is high from the cycle after an accepted start (cnt>=2) until the cycle in which the last shift occurs. For cnt==1 busy never rises; done pulses the following cycle.
- Latency summary:
  - single ops: Q valid 1 cycle after the edge.
  - burst of n>=1: Q final after n edges (with E high); done high in cycle n+1.
- Large cnt: values above WIDTH are legal. Rotates cycle; shifts fill fully with serial input.
- zero reflects the current Q at all times, including the reset value.

Test Plan:
- Reset/enable (WIDTH=4, RESET_VALUE=4'hA): hold rst=0 for 2 edges -> Q=1010, busy=0, done=0, carry=0. With rst=1, E=0, mode=001, D=0101 -> Q stays 1010. Set E=1 -> Q=0101 after one edge.
- Shift/rotate singles: load 1001.
  - SHL with sin_r=1 -> Q=0011, carry=1.
  - then ROR -> Q=1001, carry=1.
  - then SHR with sin_l=0 -> Q=0100, carry=1.
- Inc/dec wrap: load 1111, INC -> Q=0000, carry=1, zero=1. DEC -> Q=1111, carry=1. DEC -> Q=1110, carry=0.
- Burst: load 0001, start=1, mode=100 (ROL), cnt=3 for one cycle, then drive mode=001, D=0000 -> inputs ignored.
  - Q goes 0010, 0100, 1000 on successive edges.
  - busy high for 2 cycles.
  - done pulses once; FSM then back in IDLE.
- Burst with pause and cnt=0: start ROR cnt=4 on 1000, drop E for 3 cycles mid-burst -> Q and busy frozen; resumes and completes at 1000 after 4 active edges. Then start with cnt=0 -> done pulses next cycle, Q unchanged.
- Reset mid-burst: start SHL cnt=4, assert rst=0 after 2 shifts -> next edge Q=RESET_VALUE, busy=0, and no done pulse ever appears for that burst.
